// File: rtl/operand_loader_pkg.sv
// Shared types and widths for the operand loader.
// Optional button filtering is enabled with OPERAND_LOADER_DEBOUNCE_EN.
package operand_loader_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } state_t;

endpackage

// File: rtl/operand_loader_button_debounce.sv
// Button conditioning: 2-flop synchronizer, optional stability filter
// (OPERAND_LOADER_DEBOUNCE_EN), and a single-cycle rising-edge pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2;
  logic live1, live2;
  logic level, level_d;
  logic armed;

  // live2 marks that sync2 now carries real samples rather than reset values
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      live1 <= 1'b0;
      live2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      live1 <= 1'b1;
      live2 <= live1;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  logic [15:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 != level) begin
      if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES != 0);
  assign level      = sync2;
`endif

  // A button held through reset must be seen released before any press counts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      armed   <= armed | (live2 & ~sync2 & ~level);
      level_d <= level;
      pulse   <= armed & level & ~level_d;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Three-step operand entry (A, B, opcode) driven by enter/clear buttons,
// then a valid/ready command issue. Filter macro: OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_enter,
  input  logic              btn_clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic [OP_W-1:0]   selector,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   op,
  output logic [1:0]        step
);

  state_t state;
  logic   enter_pulse, clear_pulse;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock (clock),
    .reset (reset),
    .btn   (btn_enter),
    .pulse (enter_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock (clock),
    .reset (reset),
    .btn   (btn_clear),
    .pulse (clear_pulse)
  );

  assign step = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= LOAD_A;
      A         <= '0;
      B         <= '0;
      op        <= '0;
      cmd_valid <= 1'b0;
    end else if (clear_pulse) begin
      // Clear wins over enter; a coincident transfer still completes on this edge
      state     <= LOAD_A;
      A         <= '0;
      B         <= '0;
      op        <= '0;
      cmd_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A: if (enter_pulse) begin
          A     <= data_in;
          state <= LOAD_B;
        end
        LOAD_B: if (enter_pulse) begin
          B     <= data_in;
          state <= LOAD_OP;
        end
        LOAD_OP: if (enter_pulse) begin
          op        <= selector;
          state     <= ISSUE;
          cmd_valid <= 1'b1;
        end
        ISSUE: if (cmd_ready) begin
          state     <= LOAD_A;
          cmd_valid <= 1'b0;
        end
        default: begin
          state     <= LOAD_A;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader against a step/operand reference model.
module tb_operand_loader;

  localparam int DEB = 16;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] data_in = '0;
  logic [3:0] selector = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [7:0] A, B;
  logic [3:0] op;
  logic [1:0] step;

  int errors = 0;
  int checks = 0;

  // reference model: which operand is next and what has been captured
  logic [1:0] m_step = 2'd0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_op = '0;

  operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .data_in   (data_in),
    .selector  (selector),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .step      (step)
  );

  always #5 clock = ~clock;

  function automatic logic [22:0] expected();
    return {m_step, m_a, m_b, m_op, (m_step == 2'd3)};
  endfunction

  task automatic model_accept_enter();
    case (m_step)
      2'd0: begin m_a = data_in; m_step = 2'd1; end
      2'd1: begin m_b = data_in; m_step = 2'd2; end
      2'd2: begin m_op = selector; m_step = 2'd3; end
      default: ;
    endcase
  endtask

  task automatic model_clear();
    m_step = 2'd0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  // one full press/release; clr presses clear together with enter
  task automatic press(input logic clr, input string name);
    @(negedge clock);
    btn_enter = 1'b1;
    btn_clear = clr;
    repeat (LAT) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL %s early: got %h want %h", name, {step, A, B, op, cmd_valid}, expected());
    end
    @(posedge clock);
    if (clr) model_clear(); else model_accept_enter();
    @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL %s capture: got %h want %h", name, {step, A, B, op, cmd_valid}, expected());
    end
    if (m_step == 2'd3 && cmd_ready) begin
      m_step = 2'd0;
      @(negedge clock);
      checks++;
      if ({step, A, B, op, cmd_valid} !== expected()) begin
        errors++;
        $display("FAIL %s transfer: got %h want %h", name, {step, A, B, op, cmd_valid}, expected());
      end
    end
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (LAT + 2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", {step, A, B, op, cmd_valid});
    end
    reset = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_full_cycle();
    cmd_ready = 1'b1;
    data_in = 8'h12; press(1'b0, "full_a");
    data_in = 8'h34; press(1'b0, "full_b");
    selector = 4'h3; press(1'b0, "full_op");
    checks++;
    if ({A, B, op} !== {8'h12, 8'h34, 4'h3}) begin
      errors++;
      $display("FAIL full_regs: got %h want 12343", {A, B, op});
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_random_cycles();
    for (int n = 0; n < 4; n++) begin
      cmd_ready = 1'b0;
      data_in = 8'($urandom); press(1'b0, "rand_a");
      data_in = 8'($urandom); press(1'b0, "rand_b");
      selector = 4'($urandom); press(1'b0, "rand_op");
      repeat ($urandom_range(1, 8)) begin
        data_in = 8'($urandom);
        selector = 4'($urandom);
        @(negedge clock);
      end
      checks++;
      if ({step, A, B, op, cmd_valid} !== expected()) begin
        errors++;
        $display("FAIL rand_hold: got %h want %h", {step, A, B, op, cmd_valid}, expected());
      end
      cmd_ready = 1'b1;
      @(negedge clock);
      m_step = 2'd0;
      checks++;
      if ({step, A, B, op, cmd_valid} !== expected()) begin
        errors++;
        $display("FAIL rand_xfer: got %h want %h", {step, A, B, op, cmd_valid}, expected());
      end
      cmd_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    cmd_ready = 1'b0;
    data_in = 8'($urandom); press(1'b0, "bp_a");
    data_in = 8'($urandom); press(1'b0, "bp_b");
    selector = 4'($urandom); press(1'b0, "bp_op");
    for (int i = 0; i < 50; i++) begin
      data_in = 8'($urandom);
      selector = 4'($urandom);
      btn_enter = (i >= 5 && i < 35);
      @(negedge clock);
      if ({step, A, B, op, cmd_valid} !== expected()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d cycles differed, want 0", bad);
    end
    btn_enter = 1'b0;
    repeat (LAT + 2) @(negedge clock);
    cmd_ready = 1'b1;
    @(negedge clock);
    m_step = 2'd0;
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL backpressure_xfer: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_hold_single_pulse();
    @(negedge clock);
    data_in = 8'($urandom);
    btn_enter = 1'b1;
    repeat (3 * LAT + 10) @(negedge clock);
    model_accept_enter();
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL hold_one_pulse: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    btn_enter = 1'b0;
    repeat (LAT + 2) @(negedge clock);
  endtask

  task automatic test_bounce();
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    data_in = 8'($urandom);
    for (int g = 0; g < 5; g++) begin
      btn_enter = 1'b1;
      repeat (10) @(negedge clock);
      btn_enter = 1'b0;
      repeat (10) @(negedge clock);
    end
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL bounce_glitch: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    btn_enter = 1'b1;
    repeat (19) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL bounce_early: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    @(posedge clock);
    model_accept_enter();
    @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL bounce_accept: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    repeat (30) @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL bounce_single: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    btn_enter = 1'b0;
    repeat (LAT + 2) @(negedge clock);
`endif
  endtask

  task automatic test_clear_priority();
    if (m_step != 2'd0) begin
      @(negedge clock);
      btn_clear = 1'b1;
      repeat (LAT + 2) @(negedge clock);
      model_clear();
      btn_clear = 1'b0;
      repeat (LAT + 2) @(negedge clock);
    end
    data_in = 8'hAA; press(1'b0, "clr_setup");
    checks++;
    if ({step, A} !== {2'd1, 8'hAA}) begin
      errors++;
      $display("FAIL clr_setup_state: got %h want 1aa", {step, A});
    end
    data_in = 8'h55;
    press(1'b1, "clr_priority");
  endtask

  task automatic test_reset_mid_issue();
    cmd_ready = 1'b0;
    data_in = 8'($urandom); press(1'b0, "rst_a");
    data_in = 8'($urandom); press(1'b0, "rst_b");
    selector = 4'($urandom); press(1'b0, "rst_op");
    @(posedge clock);
    #2;
    reset = 1'b0;
    btn_enter = 1'b1;
    #1;
    model_clear();
    checks++;
    if ({step, A, B, op, cmd_valid} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", {step, A, B, op, cmd_valid});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3 * LAT + 20) @(negedge clock);
    checks++;
    if ({step, A, B, op, cmd_valid} !== expected()) begin
      errors++;
      $display("FAIL reset_held_btn: got %h want %h", {step, A, B, op, cmd_valid}, expected());
    end
    btn_enter = 1'b0;
    repeat (LAT + 4) @(negedge clock);
    data_in = 8'($urandom);
    press(1'b0, "reset_rearm");
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_random_cycles();
    test_backpressure();
    test_hold_single_pulse();
    test_bounce();
    test_clear_priority();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
